arcade_input_cond: RTL and testbench



---
 rtl/arcade_input_cond.sv | 231 +++++++++++++++++++++++
 tb/tb_arcade_input_cond.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_cond.sv
// Conditions the merged MiSTer joystick word into registered, SOCD-cleaned arcade controls
// with coin pulse shaping, autofire, pause toggle and a delayed screen-dim request.
module arcade_input_cond #(
  parameter int unsigned TICK_DIV    = 18432,
  parameter int unsigned COIN_MS     = 100,
  parameter int unsigned COIN_GAP_MS = 100,
  parameter int unsigned AF_HALF_MS  = 50,
  parameter int unsigned DIM_MS      = 10000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] joy_in,
  input  logic        autofire_en,
  input  logic        freeze,
  output logic        up,
  output logic        down,
  output logic        left,
  output logic        right,
  output logic        fire,
  output logic        bomb,
  output logic        start1,
  output logic        start2,
  output logic        coin,
  output logic        pause,
  output logic        dim
);

  localparam int unsigned TickW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CoinMax = (COIN_MS > COIN_GAP_MS) ? COIN_MS : COIN_GAP_MS;
  localparam int unsigned CoinW   = $clog2(CoinMax + 1);
  localparam int unsigned AfW     = $clog2(AF_HALF_MS + 1);
  localparam int unsigned DimW    = $clog2(DIM_MS + 1);

  typedef enum logic [1:0] {StIdle, StPulse, StGap} coin_state_e;

  // 1 ms tick prescaler, free-running through freeze
  logic [TickW-1:0] tick_cnt_q;
  logic             tick;

  assign tick = (tick_cnt_q == TickW'(TICK_DIV - 1));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TickW'(1);
    end
  end

  // Input register and edge-detect history; history keeps sampling during freeze
  logic [15:0] j_q;
  logic        coin_prev_q, pause_prev_q;
  logic        coin_edge, pause_edge;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      j_q          <= '0;
      coin_prev_q  <= 1'b0;
      pause_prev_q <= 1'b0;
    end else begin
      j_q          <= joy_in;
      coin_prev_q  <= j_q[8];
      pause_prev_q <= j_q[9];
    end
  end

  assign coin_edge  = j_q[8] & ~coin_prev_q;
  assign pause_edge = j_q[9] & ~pause_prev_q;

  // Pad outputs: {start2, start1, bomb, up, down, left, right}
  logic [6:0]     pad_d, pad_q;
  logic           fire_d, fire_q;
  logic           af_active;
  logic [AfW-1:0] af_cnt_d, af_cnt_q;
  logic           af_phase_d, af_phase_q;

  assign af_active = autofire_en & j_q[10];

  always_comb begin
    af_cnt_d   = af_cnt_q;
    af_phase_d = af_phase_q;
    if (freeze || !af_active) begin
      af_cnt_d   = '0;
      af_phase_d = 1'b0;
    end else if (tick) begin
      if (af_cnt_q >= AfW'(AF_HALF_MS - 1)) begin
        af_cnt_d   = '0;
        af_phase_d = ~af_phase_q;
      end else begin
        af_cnt_d = af_cnt_q + AfW'(1);
      end
    end
  end

  always_comb begin
    pad_d  = '0;
    fire_d = 1'b0;
    if (!freeze) begin
      pad_d[0] = j_q[0] & ~j_q[1];
      pad_d[1] = j_q[1] & ~j_q[0];
      pad_d[2] = j_q[2] & ~j_q[3];
      pad_d[3] = j_q[3] & ~j_q[2];
      pad_d[4] = j_q[5];
      pad_d[5] = j_q[6];
      pad_d[6] = j_q[7];
      // phase 0 is the high half, so fire rises on the first active cycle
      fire_d   = j_q[4] | (af_active & ~af_phase_q);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pad_q      <= '0;
      fire_q     <= 1'b0;
      af_cnt_q   <= '0;
      af_phase_q <= 1'b0;
    end else begin
      pad_q      <= pad_d;
      fire_q     <= fire_d;
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
    end
  end

  // Pause toggle and dim counter
  logic            pause_d, pause_q;
  logic [DimW-1:0] dim_cnt_d, dim_cnt_q;

  always_comb begin
    pause_d   = freeze ? 1'b0 : (pause_q ^ pause_edge);
    dim_cnt_d = dim_cnt_q;
    if (!pause_d) begin
      dim_cnt_d = '0;
    end else if (pause_q && tick && (dim_cnt_q < DimW'(DIM_MS))) begin
      dim_cnt_d = dim_cnt_q + DimW'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pause_q   <= 1'b0;
      dim_cnt_q <= '0;
    end else begin
      pause_q   <= pause_d;
      dim_cnt_q <= dim_cnt_d;
    end
  end

  // Coin pulse shaper
  coin_state_e      coin_state_d, coin_state_q;
  logic [CoinW-1:0] coin_cnt_d, coin_cnt_q;
  logic             pending_d, pending_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      coin_state_q <= StIdle;
      coin_cnt_q   <= '0;
      pending_q    <= 1'b0;
    end else begin
      coin_state_q <= coin_state_d;
      coin_cnt_q   <= coin_cnt_d;
      pending_q    <= pending_d;
    end
  end

  always_comb begin
    coin_state_d = coin_state_q;
    coin_cnt_d   = coin_cnt_q;
    pending_d    = pending_q;
    unique case (coin_state_q)
      StIdle: begin
        if (coin_edge || pending_q) begin
          coin_state_d = StPulse;
          coin_cnt_d   = CoinW'(COIN_MS);
          pending_d    = 1'b0;
        end
      end
      StPulse: begin
        if (coin_edge) pending_d = 1'b1;
        if (tick) begin
          if (coin_cnt_q <= CoinW'(1)) begin
            coin_state_d = StGap;
            coin_cnt_d   = CoinW'(COIN_GAP_MS);
          end else begin
            coin_cnt_d = coin_cnt_q - CoinW'(1);
          end
        end
      end
      StGap: begin
        // an edge on the expiring cycle is kept as pending and served from idle
        if (coin_edge) pending_d = 1'b1;
        if (tick) begin
          if (coin_cnt_q <= CoinW'(1)) begin
            coin_state_d = StIdle;
            coin_cnt_d   = '0;
          end else begin
            coin_cnt_d = coin_cnt_q - CoinW'(1);
          end
        end
      end
      default: begin
        coin_state_d = StIdle;
        coin_cnt_d   = '0;
      end
    endcase
    if (freeze) begin
      coin_state_d = StIdle;
      coin_cnt_d   = '0;
      pending_d    = 1'b0;
    end
  end

  always_comb begin
    coin = 1'b0;
    if (coin_state_q == StPulse) coin = 1'b1;
  end

  assign right  = pad_q[0];
  assign left   = pad_q[1];
  assign down   = pad_q[2];
  assign up     = pad_q[3];
  assign bomb   = pad_q[4];
  assign start1 = pad_q[5];
  assign start2 = pad_q[6];
  assign fire   = fire_q;
  assign pause  = pause_q;
  assign dim    = pause_q & (dim_cnt_q == DimW'(DIM_MS));

endmodule

// File: tb/tb_arcade_input_cond.sv
// Directed bench for arcade_input_cond with shortened timing parameters.
module tb_arcade_input_cond;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] joy_in = '0;
  logic        autofire_en = 1'b0;
  logic        freeze = 1'b0;
  logic        up, down, left, right, fire, bomb, start1, start2, coin, pause, dim;

  int checks = 0;
  int errors = 0;

  arcade_input_cond #(
    .TICK_DIV   (4),
    .COIN_MS    (3),
    .COIN_GAP_MS(2),
    .AF_HALF_MS (2),
    .DIM_MS     (5)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .joy_in     (joy_in),
    .autofire_en(autofire_en),
    .freeze     (freeze),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .fire       (fire),
    .bomb       (bomb),
    .start1     (start1),
    .start2     (start2),
    .coin       (coin),
    .pause      (pause),
    .dim        (dim)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [10:0] outs();
    return {up, down, left, right, fire, bomb, start1, start2, coin, pause, dim};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int   n, pulses, w1, w2, gap, low_after, last_c, ntog;
    logic prev_c, ok;
    logic f [40];

    // Reset and idle
    step(3);
    check("reset outs", 32'(outs()), 32'd0);
    reset = 1'b0;
    step(3);
    check("idle outs", 32'(outs()), 32'd0);

    // SOCD and latency
    joy_in = 16'h0003; step(2);
    check("lr socd", 32'({left, right}), 32'd0);
    joy_in = 16'h000C; step(2);
    check("ud socd", 32'({up, down}), 32'd0);
    joy_in = 16'h0002; step(2);
    check("left alone", 32'({left, right}), 32'd2);
    joy_in = 16'h0000; step(2);
    joy_in = 16'h0001; step(1);
    check("right lat1", 32'(right), 32'd0);
    step(1);
    check("right lat2", 32'(right), 32'd1);
    joy_in = 16'h00F0; step(2);
    check("buttons", 32'({fire, bomb, start1, start2}), 32'hF);
    joy_in = 16'h0000; step(3);

    // Coin held 40 cycles -> one pulse
    pulses = 0; w1 = 0; low_after = 0; prev_c = 1'b0;
    for (int c = 0; c < 70; c++) begin
      joy_in = (c < 40) ? 16'h0100 : 16'h0000;
      step(1);
      if (coin) begin
        if (!prev_c) pulses++;
        if (pulses == 1) w1++;
      end else if (pulses >= 1) begin
        low_after++;
      end
      prev_c = coin;
    end
    check("held coin pulses", 32'(pulses), 32'd1);
    check($sformatf("coin width %0d in 9..12", w1), 32'(w1 >= 9 && w1 <= 12), 32'd1);
    check($sformatf("coin low after %0d >= 8", low_after), 32'(low_after >= 8), 32'd1);
    step(20);

    // Edges at 0, 4, 8 -> exactly two pulses separated by the gap
    pulses = 0; w1 = 0; w2 = 0; gap = 0; prev_c = 1'b0;
    for (int c = 0; c < 80; c++) begin
      joy_in = (c == 0 || c == 4 || c == 8) ? 16'h0100 : 16'h0000;
      step(1);
      if (coin) begin
        if (!prev_c) pulses++;
        if (pulses == 1) w1++;
        if (pulses == 2) w2++;
      end else if (pulses == 1) begin
        gap++;
      end
      prev_c = coin;
    end
    check("multi coin pulses", 32'(pulses), 32'd2);
    check($sformatf("coin gap %0d in 6..10", gap), 32'(gap >= 6 && gap <= 10), 32'd1);
    check($sformatf("second width %0d in 9..12", w2), 32'(w2 >= 9 && w2 <= 12), 32'd1);
    step(20);

    // Autofire
    autofire_en = 1'b1;
    joy_in = 16'h0400;
    for (int c = 0; c < 40; c++) begin
      step(1);
      f[c] = fire;
    end
    check("af before", 32'(f[0]), 32'd0);
    check("af first", 32'(f[1]), 32'd1);
    last_c = 1; ntog = 0;
    for (int c = 2; c < 40; c++) begin
      if (f[c] != f[c-1]) begin
        check($sformatf("af half %0d in 5..11", c - last_c),
              32'((c - last_c) >= 5 && (c - last_c) <= 11), 32'd1);
        ntog++;
        last_c = c;
      end
    end
    check($sformatf("af toggles %0d >= 3", ntog), 32'(ntog >= 3), 32'd1);
    joy_in = 16'h0000; step(2);
    check("af release", 32'(fire), 32'd0);
    autofire_en = 1'b0;
    joy_in = 16'h0400;
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (fire) ok = 1'b0;
    end
    check("af disabled", 32'(ok), 32'd1);
    joy_in = 16'h0000; step(2);

    // Pause and dim
    joy_in = 16'h0200; step(1);
    joy_in = 16'h0000;
    n = 0;
    while (!pause && n < 5) begin step(1); n++; end
    check("pause on", 32'(pause), 32'd1);
    check("dim early", 32'(dim), 32'd0);
    n = 0;
    while (!dim && n < 30) begin step(1); n++; end
    check($sformatf("dim delay %0d in 17..20", n), 32'(n >= 17 && n <= 20), 32'd1);
    joy_in = 16'h0200; step(1);
    joy_in = 16'h0000;
    n = 0;
    while (pause && n < 5) begin step(1); n++; end
    check("pause off", 32'(pause), 32'd0);
    check("dim with pause off", 32'(dim), 32'd0);
    joy_in = 16'h0200; step(1);
    joy_in = 16'h0000;
    n = 0;
    while (!pause && n < 5) begin step(1); n++; end
    check("pause on again", 32'(pause), 32'd1);
    check("dim counter cleared", 32'(dim), 32'd0);

    // Freeze wins over a pause edge; held bit9 across release makes no edge
    joy_in = 16'h02F0;
    freeze = 1'b1;
    step(2);
    check("freeze pause", 32'(pause), 32'd0);
    check("freeze outs", 32'(outs()), 32'd0);
    freeze = 1'b0;
    step(4);
    check("pause after freeze", 32'(pause), 32'd0);
    check("buttons after freeze", 32'({fire, bomb, start1, start2}), 32'hF);
    joy_in = 16'h0000; step(3);

    // Asynchronous reset mid-pulse
    joy_in = 16'h0200; step(1);
    joy_in = 16'h0000; step(3);
    joy_in = 16'h0100; step(1);
    joy_in = 16'h0000;
    n = 0;
    while (!coin && n < 5) begin step(1); n++; end
    check("pre-reset coin/pause", 32'({coin, pause}), 32'd3);
    reset = 1'b1;
    #1;
    check("async reset", 32'({coin, pause, dim}), 32'd0);
    step(2);
    reset = 1'b0;
    step(5);
    check("post reset idle", 32'(outs()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
